mem_bus_arbiter: RTL and testbench

//  Shares one physical memory bus between two masters: port 0 (CPU_MMU) and port 1 (DMA/loader).

---
 rtl/mem_bus_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one memory bus between two masters: port 0 (CPU/MMU) and port 1 (DMA/loader).
//   Requests are arbitrated round-robin per transaction. The grant and the bus address, write
//   data and access type are registered. Ready and read data go straight back to the master.
//   A watchdog aborts an access that never sees mem_ready.
//
//   Access codes (3 bits): 0 = NONE, 1 = R (read), 2 = W (write), 3 = X (fetch).
//   Any other code means "no request".
//
// Parameters
//   TIMEOUT         S_ACCESS cycles without mem_ready before the access is aborted (0 = off)
// Ports
//   clk             clock, all state on posedge
//   res             synchronous active-high reset
//   mN_addr         port N address
//   mN_dataOut      port N write data
//   mN_accessType   port N request type
//   mN_dataIn       port N read data (always equal to mem_dataIn)
//   mN_ready        port N done / idle
//   mN_err          port N access aborted by the watchdog
//   mem_addr        bus address (registered)
//   mem_dataOut     bus write data (registered)
//   mem_accessType  bus request type (NONE outside the access state)
//   mem_dataIn      bus read data
//   mem_ready       bus completion strobe
//   grant           index of the port that owns the bus
//   busy            arbiter is not idle
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        res,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_dataOut,
    input  logic [2:0]  m0_accessType,
    output logic [31:0] m0_dataIn,
    output logic        m0_ready,
    output logic        m0_err,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_dataOut,
    input  logic [2:0]  m1_accessType,
    output logic [31:0] m1_dataIn,
    output logic        m1_ready,
    output logic        m1_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_dataOut,
    output logic [2:0]  mem_accessType,
    input  logic [31:0] mem_dataIn,
    input  logic        mem_ready,
    output logic        grant,
    output logic        busy
);

    localparam logic [2:0] AccNone  = 3'd0;
    localparam logic [2:0] AccRead  = 3'd1;
    localparam logic [2:0] AccWrite = 3'd2;
    localparam logic [2:0] AccFetch = 3'd3;

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StAccess = 2'd1;
    localparam logic [1:0] StAbort  = 2'd2;

    // Keep the counter at least one bit wide so TIMEOUT=0 still elaborates.
    localparam int unsigned    WdW    = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT - 1);
    localparam logic [WdW-1:0] WdMax  = '1;
    localparam logic           WdOn   = (TIMEOUT != 0);

    logic [1:0]     state_q;
    logic           grant_q;
    logic           last_grant_q;
    logic [WdW-1:0] wd_cnt_q;
    logic [31:0]    addr_q;
    logic [31:0]    wdata_q;
    logic [2:0]     type_q;

    logic req0, req1, winner, done;

    function automatic logic is_req(input logic [2:0] t);
        return (t == AccRead) || (t == AccWrite) || (t == AccFetch);
    endfunction

    assign req0 = is_req(m0_accessType);
    assign req1 = is_req(m1_accessType);

    // On a tie the port that did not own the previous transaction wins.
    assign winner = (req0 && req1) ? ~last_grant_q : req1;

    always_ff @(posedge clk) begin
        if (res) begin
            state_q      <= StIdle;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            wd_cnt_q     <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            type_q       <= AccNone;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req0 || req1) begin
                        grant_q  <= winner;
                        addr_q   <= winner ? m1_addr : m0_addr;
                        wdata_q  <= winner ? m1_dataOut : m0_dataOut;
                        type_q   <= winner ? m1_accessType : m0_accessType;
                        wd_cnt_q <= '0;
                        state_q  <= StAccess;
                    end
                end
                StAccess: begin
                    if (mem_ready) begin
                        last_grant_q <= grant_q;
                        wd_cnt_q     <= '0;
                        state_q      <= StIdle;
                    end else begin
                        if (WdOn && (wd_cnt_q != WdMax)) begin
                            wd_cnt_q <= wd_cnt_q + WdW'(1);
                        end
                        if (WdOn && (wd_cnt_q == WdLast)) begin
                            state_q <= StAbort;
                        end
                    end
                end
                StAbort: begin
                    last_grant_q <= grant_q;
                    wd_cnt_q     <= '0;
                    state_q      <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Completion or abort cycle of the granted port; mem_ready outside StAccess is ignored.
    assign done = ((state_q == StAccess) && mem_ready) || (state_q == StAbort);

    assign m0_ready = ~req0 || (done && !grant_q);
    assign m1_ready = ~req1 || (done && grant_q);
    assign m0_err   = (state_q == StAbort) && !grant_q;
    assign m1_err   = (state_q == StAbort) && grant_q;

    assign m0_dataIn = mem_dataIn;
    assign m1_dataIn = mem_dataIn;

    assign mem_addr       = addr_q;
    assign mem_dataOut    = wdata_q;
    assign mem_accessType = (state_q == StAccess) ? type_q : AccNone;
    assign grant          = grant_q;
    assign busy           = (state_q != StIdle);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        res = 1'b1;
    logic [31:0] m0_addr = '0, m0_dataOut = '0, m1_addr = '0, m1_dataOut = '0;
    logic [2:0]  m0_accessType = 3'd0, m1_accessType = 3'd0;
    logic [31:0] m0_dataIn, m1_dataIn, mem_addr, mem_dataOut;
    logic        m0_ready, m0_err, m1_ready, m1_err;
    logic [2:0]  mem_accessType;
    logic [31:0] mem_dataIn = '0;
    logic        mem_ready = 1'b0;
    logic        grant, busy;

    int n_cmp = 0;
    int n_err = 0;

    mem_bus_arbiter #(.TIMEOUT(4)) dut (
        .clk(clk), .res(res),
        .m0_addr(m0_addr), .m0_dataOut(m0_dataOut), .m0_accessType(m0_accessType),
        .m0_dataIn(m0_dataIn), .m0_ready(m0_ready), .m0_err(m0_err),
        .m1_addr(m1_addr), .m1_dataOut(m1_dataOut), .m1_accessType(m1_accessType),
        .m1_dataIn(m1_dataIn), .m1_ready(m1_ready), .m1_err(m1_err),
        .mem_addr(mem_addr), .mem_dataOut(mem_dataOut), .mem_accessType(mem_accessType),
        .mem_dataIn(mem_dataIn), .mem_ready(mem_ready),
        .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        res = 1'b1;
        cyc();
        res = 1'b0;
        #1;
    endtask

    initial begin
        cyc();
        cyc();
        res = 1'b0;
        #1;
        // Reset state
        check("rst busy", 32'(busy), 32'd0);
        check("rst type", 32'(mem_accessType), 32'd0);
        check("rst addr", mem_addr, 32'd0);
        check("rst wdata", mem_dataOut, 32'd0);
        check("rst grant", 32'(grant), 32'd0);
        check("rst m0_ready", 32'(m0_ready), 32'd1);
        check("rst m1_ready", 32'(m1_ready), 32'd1);
        check("rst m0_err", 32'(m0_err), 32'd0);
        check("rst m1_err", 32'(m1_err), 32'd0);

        // mem_ready in idle is ignored
        mem_ready = 1'b1;
        cyc();
        check("idle mem_ready busy", 32'(busy), 32'd0);
        mem_ready = 1'b0;

        // 1: single read
        m0_addr = 32'h100;
        m0_accessType = 3'd1;
        #1;
        check("t1 req m0_ready", 32'(m0_ready), 32'd0);
        check("t1 req busy", 32'(busy), 32'd0);
        cyc();
        check("t1 addr", mem_addr, 32'h100);
        check("t1 grant", 32'(grant), 32'd0);
        for (int c = 0; c < 3; c++) begin
            check("t1 wait m0_ready", 32'(m0_ready), 32'd0);
            check("t1 wait m1_ready", 32'(m1_ready), 32'd1);
            check("t1 wait type", 32'(mem_accessType), 32'd1);
            cyc();
        end
        mem_ready = 1'b1;
        mem_dataIn = 32'hDEADBEEF;
        #1;
        check("t1 done m0_ready", 32'(m0_ready), 32'd1);
        check("t1 done m0_dataIn", m0_dataIn, 32'hDEADBEEF);
        check("t1 done m1_ready", 32'(m1_ready), 32'd1);
        check("t1 done err", 32'(m0_err), 32'd0);
        cyc();
        mem_ready = 1'b0;
        m0_accessType = 3'd0;
        #1;
        check("t1 after busy", 32'(busy), 32'd0);
        check("t1 after type", 32'(mem_accessType), 32'd0);

        // 2: contention right after reset, port 0 first
        do_reset();
        m0_addr = 32'h10;
        m0_dataOut = 32'h0000AAAA;
        m0_accessType = 3'd2;
        m1_addr = 32'h20;
        m1_accessType = 3'd1;
        #1;
        cyc();
        check("t2 a grant", 32'(grant), 32'd0);
        check("t2 a addr", mem_addr, 32'h10);
        check("t2 a wdata", mem_dataOut, 32'h0000AAAA);
        check("t2 a type", 32'(mem_accessType), 32'd2);
        check("t2 a m1_ready", 32'(m1_ready), 32'd0);
        cyc();
        mem_ready = 1'b1;
        #1;
        check("t2 a done m0_ready", 32'(m0_ready), 32'd1);
        check("t2 a done m1_ready", 32'(m1_ready), 32'd0);
        cyc();
        mem_ready = 1'b0;
        m0_accessType = 3'd0;
        #1;
        check("t2 idle busy", 32'(busy), 32'd0);
        check("t2 idle m1_ready", 32'(m1_ready), 32'd0);
        cyc();
        check("t2 b grant", 32'(grant), 32'd1);
        check("t2 b addr", mem_addr, 32'h20);
        check("t2 b type", 32'(mem_accessType), 32'd1);
        check("t2 b m1_ready", 32'(m1_ready), 32'd0);
        cyc();
        mem_ready = 1'b1;
        mem_dataIn = 32'h00001234;
        #1;
        check("t2 b done m1_ready", 32'(m1_ready), 32'd1);
        check("t2 b done m1_dataIn", m1_dataIn, 32'h00001234);
        check("t2 b done m0_ready", 32'(m0_ready), 32'd1);
        cyc();
        mem_ready = 1'b0;
        #1;

        // 3: fairness, both ports requesting continuously (last grant was port 1)
        m0_accessType = 3'd1;
        m1_accessType = 3'd1;
        #1;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("t3 idle %0d busy", i), 32'(busy), 32'd0);
            cyc();
            check($sformatf("t3 txn %0d busy", i), 32'(busy), 32'd1);
            check($sformatf("t3 txn %0d grant", i), 32'(grant), 32'(i % 2));
            mem_ready = 1'b1;
            #1;
            check($sformatf("t3 txn %0d ready", i), 32'((i % 2) ? m1_ready : m0_ready), 32'd1);
            check($sformatf("t3 txn %0d loser", i), 32'((i % 2) ? m0_ready : m1_ready), 32'd0);
            cyc();
            mem_ready = 1'b0;
            #1;
        end
        m0_accessType = 3'd0;
        m1_accessType = 3'd0;
        #1;

        // 4: watchdog abort with TIMEOUT=4
        m1_addr = 32'h40;
        m1_accessType = 3'd3;
        #1;
        cyc();
        check("t4 grant", 32'(grant), 32'd1);
        check("t4 addr", mem_addr, 32'h40);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t4 acc %0d type", k), 32'(mem_accessType), 32'd3);
            check($sformatf("t4 acc %0d m1_ready", k), 32'(m1_ready), 32'd0);
            check($sformatf("t4 acc %0d m1_err", k), 32'(m1_err), 32'd0);
            cyc();
        end
        check("t4 abort type", 32'(mem_accessType), 32'd0);
        check("t4 abort busy", 32'(busy), 32'd1);
        check("t4 abort m1_ready", 32'(m1_ready), 32'd1);
        check("t4 abort m1_err", 32'(m1_err), 32'd1);
        check("t4 abort m0_err", 32'(m0_err), 32'd0);
        cyc();
        m1_accessType = 3'd0;
        m0_addr = 32'h50;
        m0_accessType = 3'd1;
        #1;
        check("t4 idle busy", 32'(busy), 32'd0);
        check("t4 idle m1_err", 32'(m1_err), 32'd0);
        cyc();
        check("t4 next grant", 32'(grant), 32'd0);
        check("t4 next addr", mem_addr, 32'h50);
        mem_ready = 1'b1;
        #1;
        check("t4 next m0_ready", 32'(m0_ready), 32'd1);
        cyc();
        mem_ready = 1'b0;
        m0_accessType = 3'd0;
        #1;

        // 5: reset mid-access
        m0_addr = 32'h60;
        m0_accessType = 3'd1;
        #1;
        cyc();
        check("t5 pre busy", 32'(busy), 32'd1);
        res = 1'b1;
        cyc();
        check("t5 rst busy", 32'(busy), 32'd0);
        check("t5 rst type", 32'(mem_accessType), 32'd0);
        check("t5 rst addr", mem_addr, 32'd0);
        res = 1'b0;
        m0_accessType = 3'd0;
        m1_addr = 32'h70;
        m1_accessType = 3'd1;
        #1;
        cyc();
        check("t5 grant m1", 32'(grant), 32'd1);
        check("t5 addr", mem_addr, 32'h70);
        mem_ready = 1'b1;
        #1;
        check("t5 m1_ready", 32'(m1_ready), 32'd1);
        cyc();
        mem_ready = 1'b0;
        m1_accessType = 3'd0;
        #1;
        do_reset();
        m0_accessType = 3'd1;
        m1_accessType = 3'd1;
        #1;
        cyc();
        check("t5 tie grant", 32'(grant), 32'd0);
        mem_ready = 1'b1;
        #1;
        cyc();
        mem_ready = 1'b0;
        m0_accessType = 3'd0;
        m1_accessType = 3'd0;
        #1;

        // 6: withdrawal mid-access
        m0_addr = 32'h80;
        m0_accessType = 3'd2;
        #1;
        cyc();
        check("t6 grant", 32'(grant), 32'd0);
        m0_accessType = 3'd0;
        #1;
        check("t6 drop m0_ready", 32'(m0_ready), 32'd1);
        check("t6 drop type", 32'(mem_accessType), 32'd2);
        cyc();
        check("t6 still busy", 32'(busy), 32'd1);
        check("t6 wait m0_ready", 32'(m0_ready), 32'd1);
        mem_ready = 1'b1;
        #1;
        check("t6 done m0_ready", 32'(m0_ready), 32'd1);
        check("t6 done m0_err", 32'(m0_err), 32'd0);
        cyc();
        mem_ready = 1'b0;
        #1;
        check("t6 idle busy", 32'(busy), 32'd0);
        check("t6 idle m0_err", 32'(m0_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
